acc_drain: RTL and testbench

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/acc_drain_pkg.sv | 15 +
 rtl/acc_drain_sync_fifo.sv | 61 ++++++
 rtl/acc_drain.sv | 86 ++++++++
 tb/tb_acc_drain.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/acc_drain_pkg.sv
// Shared definitions for the accumulator drain block.
//   DEF_WIDTH   default signed width of incoming partial sums
//   DEF_OWIDTH  default signed width of drained output words
//   entry_t     one buffered output word: converted data plus its clamp flag
package acc_drain_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_OWIDTH = 16;

  typedef struct packed {
    logic signed [DEF_OWIDTH-1:0] data;
    logic                         sat;
  } entry_t;

endpackage

// File: rtl/acc_drain_sync_fifo.sv
// First-word-fall-through FIFO built from registers.
//   clk, rst_n        clock, async active-low reset
//   clr_i             synchronous flush (overrides push/pop)
//   push_i, wdata_i   write one word
//   pop_i             retire the head word (caller guarantees non-empty)
//   rdata_o           head word, zero while empty
//   full_o            count_o == DEPTH
//   count_o           occupancy
module sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  // Storage is not reset; gating the head keeps the output at zero while empty.
  assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/acc_drain.sv
// Drains finished column partial sums: round, scale, saturate and buffer them
// for a ready/valid consumer.
//   clk, rst_n         clock, async active-low reset
//   en, clr            capture enable, synchronous flush of buffer and ovf flag
//   sum_vld, sum_i     finished partial sum (WIDTH signed)
//   stall_o            buffer full, array must hold the column
//   out_vld, out_rdy   output handshake
//   out_data, out_sat  converted word (OWIDTH signed) and its clamp flag
//   ovf_o              sticky: a valid sum was dropped
//   count_o            buffer occupancy
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int OWIDTH = DEF_OWIDTH,
  parameter int SHIFT  = 0,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     sum_vld,
  input  logic signed [WIDTH-1:0]  sum_i,
  output logic                     stall_o,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic signed [OWIDTH-1:0] out_data,
  output logic                     out_sat,
  output logic                     ovf_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int XW  = WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [XW-1:0] RND  = (SHIFT > 0) ? (XW'(1) << RSH) : '0;
  localparam logic signed [XW-1:0] MAXV = (XW'(1) << (OWIDTH - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -(XW'(1) << (OWIDTH - 1));

  logic signed [XW-1:0]     ext, shf;
  logic                     hi, lo, full, push, pop, ovf_q;
  logic signed [OWIDTH-1:0] conv_data;
  logic [OWIDTH:0]          wdata, rdata;

  // One guard bit means the rounding add can never wrap.
  assign ext = {sum_i[WIDTH-1], sum_i};
  assign shf = (ext + RND) >>> SHIFT;
  assign hi  = (shf > MAXV);
  assign lo  = (shf < MINV);

  always_comb begin
    conv_data = shf[OWIDTH-1:0];
    if (hi)      conv_data = MAXV[OWIDTH-1:0];
    else if (lo) conv_data = MINV[OWIDTH-1:0];
  end

  assign wdata = {conv_data, hi | lo};

  assign pop  = out_vld & out_rdy;
  assign push = en & sum_vld & ~clr & (~full | pop);

  sync_fifo #(.W(OWIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .count_o (count_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ovf_q <= 1'b0;
    else if (clr)                              ovf_q <= 1'b0;
    else if (en && sum_vld && full && !pop)    ovf_q <= 1'b1;
  end

  assign out_vld  = (count_o != '0);
  assign stall_o  = full;
  assign out_data = rdata[OWIDTH:1];
  assign out_sat  = rdata[0];
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_acc_drain.sv
module tb_acc_drain;
  import acc_drain_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, sum_vld, out_rdy;
  logic signed [31:0] sum_i;
  logic        stall_o, out_vld, out_sat, ovf_o;
  logic signed [15:0] out_data;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  entry_t q[$];
  int     exp_cnt = 0;
  logic   exp_ovf = 1'b0;

  acc_drain #(.WIDTH(32), .OWIDTH(16), .SHIFT(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sum_vld(sum_vld),
    .sum_i(sum_i), .stall_o(stall_o), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_sat(out_sat), .ovf_o(ovf_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference conversion in wide integer arithmetic: round half up, /16, clamp.
  function automatic entry_t model(input logic signed [31:0] s);
    entry_t e;
    longint v;
    v = (longint'(s) + 64'sd8) >>> 4;
    if (v > 32767)       begin e.data = 16'sd32767;  e.sat = 1'b1; end
    else if (v < -32768) begin e.data = -16'sd32768; e.sat = 1'b1; end
    else                 begin e.data = 16'(v);      e.sat = 1'b0; end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected next state comes from FIFO rules, not the RTL.
  task automatic step(input logic e, input logic v, input logic [31:0] s,
                      input logic r, input logic c);
    bit p, f, pu;
    int ncnt;
    logic novf;
    en = e; sum_vld = v; sum_i = s; out_rdy = r; clr = c;
    p  = (exp_cnt > 0) && r;
    f  = (exp_cnt == 4);
    pu = e && v && !c && (!f || p);
    ncnt = c ? 0 : exp_cnt + int'(pu) - int'(p);
    novf = c ? 1'b0 : (exp_ovf || (e && v && f && !p));
    if (pu) q.push_back(model(s));
    @(posedge clk); #1;
    if (c) q.delete();
    exp_cnt = ncnt;
    exp_ovf = novf;
  endtask

  // Monitor: head of the buffer must match the oldest expected entry every cycle it is shown.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("count", count_o, exp_cnt);
        chk("stall", stall_o, exp_cnt == 4);
        chk("ovf", ovf_o, exp_ovf);
        chk("out_vld", out_vld, exp_cnt != 0);
        if (out_vld) begin
          if (q.size() == 0) chk("q_underflow", q.size(), 1);
          else begin
            chk("out_data", out_data, q[0].data);
            chk("out_sat", out_sat, q[0].sat);
            if (out_rdy) void'(q.pop_front());
          end
        end
      end
    end
  end

  logic [31:0] bnd [8];

  initial begin
    bnd[0] = 32'h7FFFFFFF; bnd[1] = 32'h80000000; bnd[2] = 32'd524279; bnd[3] = 32'd524280;
    bnd[4] = -32'sd524288; bnd[5] = -32'sd524297; bnd[6] = -32'sd24; bnd[7] = 32'd296;
    rst_n = 1'b0; en = 0; clr = 0; sum_vld = 0; sum_i = 0; out_rdy = 0;
    #2;
    chk("rst_count", count_o, 0);
    chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_stall", stall_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single conversion with first-word-fall-through latency.
    step(1, 1, 32'd296, 1, 0);
    chk("d296_vld", out_vld, 1);
    chk("d296_data", out_data, 19);
    chk("d296_sat", out_sat, 0);
    step(0, 0, 0, 1, 0);

    // Saturation both ways, then a small negative that rounds to -1.
    step(1, 1, 32'h7FFFFFFF, 1, 0);
    chk("satp_data", out_data, 32767);
    chk("satp_sat", out_sat, 1);
    step(1, 1, 32'h80000000, 1, 0);
    chk("satn_data", out_data, -32768);
    chk("satn_sat", out_sat, 1);
    step(1, 1, -32'sd24, 1, 0);
    chk("m24_data", out_data, -1);
    chk("m24_sat", out_sat, 0);
    step(0, 0, 0, 1, 0);

    // Fill, overflow drop, simultaneous push/pop when full, drain.
    for (int i = 0; i < 4; i++) step(1, 1, 32'(i * 160 + 16), 0, 0);
    chk("full_count", count_o, 4);
    chk("full_stall", stall_o, 1);
    step(1, 1, 32'd9999, 0, 0);
    chk("drop_ovf", ovf_o, 1);
    chk("drop_count", count_o, 4);
    step(1, 1, 32'd4000, 1, 0);
    chk("pp_count", count_o, 4);
    chk("pp_stall", stall_o, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    chk("drained", count_o, 0);

    // Flush with a pending sum: clr wins, sticky flag cleared.
    for (int i = 0; i < 3; i++) step(1, 1, 32'(i * 33), 0, 0);
    step(1, 1, 32'd77, 0, 1);
    chk("clr_count", count_o, 0);
    chk("clr_vld", out_vld, 0);
    chk("clr_ovf", ovf_o, 0);

    // Asynchronous reset with two entries held.
    step(1, 1, 32'd1000, 0, 0);
    step(1, 1, 32'd2000, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_vld", out_vld, 0);
    chk("arst_data", out_data, 0);
    chk("arst_sat", out_sat, 0);
    chk("arst_stall", stall_o, 0);
    q.delete(); exp_cnt = 0; exp_ovf = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(1, 1, 32'd3000, 0, 0);
    chk("post_rst_count", count_o, 1);
    chk("post_rst_data", out_data, 188);

    // Randomised traffic with ready bursts and occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] s;
      logic r;
      case ($urandom % 3)
        0:       s = $urandom;
        1:       s = 32'($urandom_range(4000)) - 32'd2000;
        default: s = bnd[$urandom % 8];
      endcase
      r = ((i / 100) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 3 != 0);
      step($urandom % 8 != 0, $urandom % 4 != 0, s, r, $urandom % 64 == 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    chk("final_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
